// File: rtl/runtime_config.sv
// ---------------------------------------------------------------------------
// runtime_config
//
// Purpose:
//   Byte-stream configuration receiver with double-buffered field storage.
//   Frames of five bytes (0xA5, ADDR, DHI, DLO, CSUM) write a shadow copy of
//   the configuration. A commit frame (ADDR = 0xFF) arms a pending flag, and
//   the next apply_strobe copies the whole shadow into the live configuration
//   in one edge. The live copy therefore only ever changes at a safe point
//   chosen by the surrounding datapath, such as a Tx/Rx frame boundary.
//
// Ports:
//   clk_16M384      in   1                    sole clock
//   rst_16M384      in   1                    synchronous active-high reset
//   cfg_tdata       in   8                    configuration byte stream
//   cfg_tvalid      in   1                    byte valid
//   cfg_tready      out  1                    byte accepted when valid&ready
//   apply_strobe    in   1                    safe-update point
//   cfg_active      out  NUM_FIELDS*FIELD_W   live configuration, field i at
//                                             [i*FIELD_W +: FIELD_W]
//   cfg_updated     out  1                    one-cycle pulse on live load
//   commit_pending  out  1                    commit received, awaiting apply
//   cfg_busy        out  1                    parser is inside a frame
//   err_cnt         out  8                    saturating frame error count
// ---------------------------------------------------------------------------
module runtime_config #(
    parameter int NUM_FIELDS  = 9,
    parameter int FIELD_W     = 16,
    parameter logic [NUM_FIELDS*FIELD_W-1:0] DEFAULTS = {
        16'd8192, 16'd16, 16'd16, 16'd16, 16'd128,
        16'd3,    16'd0,  16'd4,  16'd8
    },
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk_16M384,
    input  logic                          rst_16M384,
    input  logic [7:0]                    cfg_tdata,
    input  logic                          cfg_tvalid,
    output logic                          cfg_tready,
    input  logic                          apply_strobe,
    output logic [NUM_FIELDS*FIELD_W-1:0] cfg_active,
    output logic                          cfg_updated,
    output logic                          commit_pending,
    output logic                          cfg_busy,
    output logic [7:0]                    err_cnt
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam logic [7:0] COMMIT_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // Expected checksum byte: XOR of header and the three payload bytes.
    function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                              input logic [7:0] dhi,
                                              input logic [7:0] dlo);
        frame_csum = HDR_BYTE ^ addr ^ dhi ^ dlo;
    endfunction

    state_t                          state_r;
    state_t                          state_next_s;
    logic [TO_W-1:0]                 to_cnt_r;
    logic [7:0]                      addr_r;
    logic [7:0]                      dhi_r;
    logic [7:0]                      dlo_r;
    logic [NUM_FIELDS*FIELD_W-1:0]   shadow_r;
    logic [NUM_FIELDS*FIELD_W-1:0]   active_r;
    logic                            updated_r;
    logic                            pending_r;
    logic                            busy_r;
    logic                            tready_r;
    logic [7:0]                      err_cnt_r;

    logic                            accept_s;
    logic                            timeout_s;
    logic                            at_csum_s;
    logic                            csum_ok_s;
    logic                            addr_in_range_s;
    logic                            shadow_we_s;
    logic                            commit_set_s;
    logic                            err_inc_s;
    logic                            load_s;
    logic [15:0]                     word_s;
    logic [FIELD_W-1:0]              wdata_s;

    // A byte is consumed only when ready is registered high, so nothing is
    // taken during reset or in the cycle before ready first rises.
    assign accept_s  = cfg_tvalid & tready_r;

    // The timeout fires on the TIMEOUT_CYC-th consecutive idle cycle inside a
    // frame; the counter holds the number of idle cycles already elapsed.
    assign timeout_s = (state_r != ST_IDLE) && !accept_s && (to_cnt_r == TO_LAST);

    // FSM state register.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: one step per accepted byte, back to idle on timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cfg_tdata == HDR_BYTE)) begin
                    state_next_s = ST_ADDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (accept_s) begin
                    state_next_s = ST_DHI;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DHI: begin
                if (accept_s) begin
                    state_next_s = ST_DLO;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DHI;
                end
            end
            ST_DLO: begin
                if (accept_s) begin
                    state_next_s = ST_CSUM;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DLO;
                end
            end
            ST_CSUM: begin
                if (accept_s || timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: frame outcome strobes consumed by the datapath.
    always_comb begin
        at_csum_s       = 1'b0;
        csum_ok_s       = 1'b0;
        addr_in_range_s = 1'b0;
        shadow_we_s     = 1'b0;
        commit_set_s    = 1'b0;
        err_inc_s       = 1'b0;
        word_s          = {dhi_r, dlo_r};
        wdata_s         = word_s[FIELD_W-1:0];
        load_s          = pending_r & apply_strobe;

        if ({1'b0, addr_r} < 9'(NUM_FIELDS)) begin
            addr_in_range_s = 1'b1;
        end else begin
            addr_in_range_s = 1'b0;
        end

        case (state_r)
            ST_CSUM: begin
                at_csum_s = accept_s;
                csum_ok_s = (cfg_tdata == frame_csum(addr_r, dhi_r, dlo_r));
                if (at_csum_s && csum_ok_s && addr_in_range_s) begin
                    shadow_we_s = 1'b1;
                end else if (at_csum_s && csum_ok_s && (addr_r == COMMIT_ADDR)) begin
                    commit_set_s = 1'b1;
                end else if (at_csum_s || timeout_s) begin
                    // bad checksum, or good checksum to an unmapped address
                    err_inc_s = 1'b1;
                end else begin
                    err_inc_s = 1'b0;
                end
            end
            ST_ADDR, ST_DHI, ST_DLO: begin
                err_inc_s = timeout_s;
            end
            default: begin
                err_inc_s = 1'b0;
            end
        endcase
    end

    // Inter-byte timeout counter; cleared by every accepted byte and whenever
    // the parser is (or is about to be) idle.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            to_cnt_r <= '0;
        end else if (accept_s || (state_next_s == ST_IDLE)) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // Capture the payload bytes of the frame in flight.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            addr_r <= 8'h00;
            dhi_r  <= 8'h00;
            dlo_r  <= 8'h00;
        end else if (accept_s) begin
            case (state_r)
                ST_ADDR: addr_r <= cfg_tdata;
                ST_DHI:  dhi_r  <= cfg_tdata;
                ST_DLO:  dlo_r  <= cfg_tdata;
                default: addr_r <= addr_r;
            endcase
        end else begin
            addr_r <= addr_r;
        end
    end

    // Shadow field writes; a write landing on the apply edge is not seen by
    // the live copy because the load samples the pre-edge shadow value.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            shadow_r <= DEFAULTS;
        end else begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (shadow_we_s && ({1'b0, addr_r} == 9'(i))) begin
                    shadow_r[i*FIELD_W +: FIELD_W] <= wdata_s;
                end
            end
        end
    end

    // Live configuration load and its aligned update pulse.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            active_r  <= DEFAULTS;
            updated_r <= 1'b0;
        end else if (load_s) begin
            active_r  <= shadow_r;
            updated_r <= 1'b1;
        end else begin
            updated_r <= 1'b0;
        end
    end

    // Commit flag. A commit frame completing on the same edge that consumes
    // the previous commit re-arms the flag, so it is never lost.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            pending_r <= 1'b0;
        end else if (commit_set_s) begin
            pending_r <= 1'b1;
        end else if (load_s) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Saturating frame error counter.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            err_cnt_r <= 8'h00;
        end else if (err_inc_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    // Registered handshake and busy flags; busy tracks the next state so it
    // lines up with the state register.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            tready_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            tready_r <= 1'b1;
            busy_r   <= (state_next_s != ST_IDLE);
        end
    end

    assign cfg_tready     = tready_r;
    assign cfg_active     = active_r;
    assign cfg_updated    = updated_r;
    assign commit_pending = pending_r;
    assign cfg_busy       = busy_r;
    assign err_cnt        = err_cnt_r;

endmodule

// File: tb/tb_runtime_config.sv
// ---------------------------------------------------------------------------
// tb_runtime_config
//
// Directed bench for runtime_config with default parameters. Inputs change
// 1 ns after the rising edge; outputs are sampled at the same point, so each
// check sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_runtime_config;

    localparam int NF  = 9;
    localparam int FW  = 16;
    localparam int TOC = 1024;
    localparam logic [NF*FW-1:0] DEF = {
        16'd8192, 16'd16, 16'd16, 16'd16, 16'd128,
        16'd3,    16'd0,  16'd4,  16'd8
    };

    logic            clk;
    logic            rst;
    logic [7:0]      tdata;
    logic            tvalid;
    logic            tready;
    logic            apply;
    logic [NF*FW-1:0] active;
    logic            updated;
    logic            pending;
    logic            busy;
    logic [7:0]      errc;

    int tests;
    int fails;

    runtime_config dut (
        .clk_16M384     (clk),
        .rst_16M384     (rst),
        .cfg_tdata      (tdata),
        .cfg_tvalid     (tvalid),
        .cfg_tready     (tready),
        .apply_strobe   (apply),
        .cfg_active     (active),
        .cfg_updated    (updated),
        .commit_pending (pending),
        .cfg_busy       (busy),
        .err_cnt        (errc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fld(input int i);
        fld = active[i*FW +: FW];
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte, accepted at the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        tdata  = b;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(h);
        send_byte(l);
        send_byte(c);
    endtask

    task automatic pulse_apply();
        apply = 1'b1;
        @(posedge clk);
        #1;
        apply = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        tdata  = 8'h00;
        tvalid = 1'b0;
        apply  = 1'b0;

        // Reset state
        idle_cycles(3);
        chk("rst_tready", tready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_updated", updated, 1'b0);
        rst = 1'b0;
        idle_cycles(1);
        chk("rel_tready", tready, 1'b1);
        chk("rel_active", active, DEF);
        chk("rel_f1", fld(1), 16'd4);
        chk("rel_f8", fld(8), 16'd8192);
        chk("rel_err", errc, 8'd0);
        chk("rel_pending", pending, 1'b0);

        // Field 1 write, commit, apply
        send_byte(8'hA5);
        chk("busy_in_frame", busy, 1'b1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hA6);
        chk("busy_after_frame", busy, 1'b0);
        chk("f1_not_live_yet", fld(1), 16'd4);
        chk("no_pending_yet", pending, 1'b0);
        send_frame(8'hFF, 8'h00, 8'h00, 8'h5A);
        chk("commit_pending", pending, 1'b1);
        chk("f1_wait_apply", fld(1), 16'd4);
        chk("no_upd_before_apply", updated, 1'b0);
        pulse_apply();
        chk("apply_updated", updated, 1'b1);
        chk("apply_f1", fld(1), 16'd2);
        chk("apply_pending_clr", pending, 1'b0);
        idle_cycles(1);
        chk("updated_one_cycle", updated, 1'b0);

        // Bad checksum and out-of-range address
        send_frame(8'h01, 8'h00, 8'h02, 8'h00);
        chk("badcsum_err", errc, 8'd1);
        chk("badcsum_pending", pending, 1'b0);
        send_frame(8'h09, 8'h00, 8'h01, 8'hAD);
        chk("badaddr_err", errc, 8'd2);
        chk("badaddr_pending", pending, 1'b0);
        send_frame(8'hFF, 8'h00, 8'h00, 8'h5A);
        pulse_apply();
        chk("err_shadow_kept_upd", updated, 1'b1);
        chk("err_shadow_kept_f1", fld(1), 16'd2);
        chk("err_shadow_kept_all", active, {DEF[NF*FW-1:32], 16'd2, 16'd8});

        // Inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h03);
        idle_cycles(TOC - 1);
        chk("to_still_busy", busy, 1'b1);
        chk("to_no_err_yet", errc, 8'd2);
        idle_cycles(1);
        chk("to_busy_clr", busy, 1'b0);
        chk("to_err", errc, 8'd3);
        send_frame(8'h03, 8'h12, 8'h34, 8'h80);
        send_frame(8'hFF, 8'h00, 8'h00, 8'h5A);
        pulse_apply();
        chk("post_to_f3", fld(3), 16'h1234);
        chk("post_to_err", errc, 8'd3);

        // Apply with nothing pending
        pulse_apply();
        chk("idle_apply_upd", updated, 1'b0);
        chk("idle_apply_f3", fld(3), 16'h1234);

        // Commit CSUM and apply on the same edge
        send_frame(8'h00, 8'h00, 8'h55, 8'hF0);
        send_byte(8'hA5);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        tdata  = 8'h5A;
        tvalid = 1'b1;
        apply  = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        apply  = 1'b0;
        chk("same_edge_commit_upd", updated, 1'b0);
        chk("same_edge_commit_pend", pending, 1'b1);
        chk("same_edge_commit_f0", fld(0), 16'd8);
        pulse_apply();
        chk("next_apply_upd", updated, 1'b1);
        chk("next_apply_f0", fld(0), 16'h0055);
        chk("next_apply_pend", pending, 1'b0);

        // Shadow write and apply on the same edge
        send_frame(8'hFF, 8'h00, 8'h00, 8'h5A);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h77);
        tdata  = 8'hD0;
        tvalid = 1'b1;
        apply  = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        apply  = 1'b0;
        chk("same_edge_wr_upd", updated, 1'b1);
        chk("same_edge_wr_f2_old", fld(2), 16'd0);
        chk("same_edge_wr_pend", pending, 1'b0);

        // Double commit then apply
        send_frame(8'hFF, 8'h00, 8'h00, 8'h5A);
        send_frame(8'hFF, 8'h00, 8'h00, 8'h5A);
        chk("double_commit_pend", pending, 1'b1);
        chk("double_commit_err", errc, 8'd3);
        pulse_apply();
        chk("late_f2", fld(2), 16'h0077);
        chk("late_pend", pending, 1'b0);

        // Error counter saturation
        for (int k = 0; k < 252; k++) begin
            send_frame(8'h01, 8'h00, 8'h02, 8'h00);
        end
        chk("err_at_255", errc, 8'd255);
        send_frame(8'h01, 8'h00, 8'h02, 8'h00);
        chk("err_saturated", errc, 8'd255);

        // Reset between DHI and DLO of a field-8 write with a commit pending
        send_frame(8'hFF, 8'h00, 8'h00, 8'h5A);
        chk("pre_rst_pend", pending, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h12);
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        send_byte(8'h34);
        chk("midrst_pend", pending, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_f8", fld(8), 16'd8192);
        chk("midrst_err", errc, 8'd0);
        chk("midrst_active", active, DEF);
        pulse_apply();
        chk("midrst_apply_upd", updated, 1'b0);
        chk("midrst_apply_f8", fld(8), 16'd8192);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
